// File: rtl/ecdsa_signer.sv
// secp256k1 ECDSA signer: checks inputs, obtains k*G from an external engine,
// then derives r and s = k^-1 (e + r*d) mod N with one shared bit-serial multiplier.
module ecdsa_signer #(
  parameter int unsigned   W          = 256,
  parameter logic [W-1:0]  N          = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEBAAEDCE6AF48A03BBFD25E8CD0364141,
  parameter int unsigned   PM_TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   msg_hash,
  input  logic [W-1:0]   priv_key,
  input  logic [W-1:0]   nonce_k,
  output logic           pm_req,
  output logic [W-1:0]   pm_scalar,
  input  logic           pm_ack,
  input  logic [W-1:0]   pm_x,
  input  logic           pm_inf,
  output logic [2*W-1:0] signature,
  output logic           busy,
  output logic           done,
  output logic           error
);

  localparam int unsigned MW = $clog2(W + 2);
  localparam int unsigned IW = $clog2(2 * W);
  localparam int unsigned TW = $clog2(PM_TIMEOUT + 1);
  localparam logic [MW-1:0] M_LAST = MW'(W + 1);
  localparam logic [IW-1:0] I_LAST = IW'(2 * W - 1);
  localparam logic [TW-1:0] T_LAST = TW'(PM_TIMEOUT - 1);
  localparam logic [W+1:0]  N2     = {2'b00, N};
  localparam logic [W:0]    N1     = {1'b0, N};

  typedef enum logic [3:0] {
    IDLE, CHECK, PM_WAIT, R_CALC, INV, MUL_RD, ADD, MUL_S, FINISH
  } state_t;

  state_t        state;
  logic [W-1:0]  e, d, k, x, r, t, w, acc, ma, mb, exp_sr;
  logic          inf;
  logic [MW-1:0] mcnt;
  logic [IW-1:0] idx;
  logic [TW-1:0] tcnt;

  logic [W-1:0]  opa, opb, mres, e_red, r_red, sum_red;
  logic [W+1:0]  step0, step1;
  logic [W:0]    sum;

  always_comb begin
    opa = w;
    opb = w;
    case (state)
      INV:     opb = idx[0] ? k : w;
      MUL_RD:  begin opa = r; opb = d; end
      MUL_S:   opb = t;
      default: ;
    endcase
    // acc < N, so 2*acc + a < 3N: two conditional subtracts restore acc < N
    step0   = {1'b0, acc, 1'b0} + (mb[W-1] ? {2'b00, ma} : '0);
    step1   = (step0 >= N2) ? step0 - N2 : step0;
    mres    = (step1 >= N2) ? W'(step1 - N2) : W'(step1);
    e_red   = (e >= N) ? e - N : e;
    r_red   = (x >= N) ? x - N : x;
    sum     = {1'b0, e} + {1'b0, t};
    sum_red = (sum >= N1) ? W'(sum - N1) : W'(sum);
  end

  // done/error/busy are updated on the edge into FINISH so the pulse occupies the FINISH cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pm_req <= 1'b0; pm_scalar <= '0; signature <= '0;
      busy <= 1'b0; done <= 1'b0; error <= 1'b0;
      e <= '0; d <= '0; k <= '0; x <= '0; r <= '0; t <= '0; w <= '0;
      acc <= '0; ma <= '0; mb <= '0; exp_sr <= '0; inf <= 1'b0;
      mcnt <= '0; idx <= '0; tcnt <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: if (start) begin
          e <= msg_hash; d <= priv_key; k <= nonce_k;
          busy <= 1'b1;
          state <= CHECK;
        end
        CHECK: if (d == '0 || d >= N || k == '0 || k >= N) begin
          error <= 1'b1; busy <= 1'b0; state <= FINISH;
        end else begin
          e <= e_red; pm_req <= 1'b1; pm_scalar <= k; tcnt <= '0;
          state <= PM_WAIT;
        end
        PM_WAIT: if (pm_ack) begin
          x <= pm_x; inf <= pm_inf;
          pm_req <= 1'b0; pm_scalar <= '0;
          state <= R_CALC;
        end else if (tcnt == T_LAST) begin
          pm_req <= 1'b0; pm_scalar <= '0;
          error <= 1'b1; busy <= 1'b0; state <= FINISH;
        end else begin
          tcnt <= tcnt + TW'(1);
        end
        R_CALC: if (inf || r_red == '0) begin
          error <= 1'b1; busy <= 1'b0; state <= FINISH;
        end else begin
          r <= r_red; w <= W'(1); exp_sr <= N - W'(2);
          idx <= '0; mcnt <= '0;
          state <= INV;
        end
        INV, MUL_RD, MUL_S: begin
          if (mcnt == '0) begin
            acc <= '0; ma <= opa; mb <= opb; mcnt <= MW'(1);
          end else if (mcnt != M_LAST) begin
            acc <= mres; mb <= mb << 1; mcnt <= mcnt + MW'(1);
          end else begin
            mcnt <= '0;
            case (state)
              INV: begin
                // even idx squares, odd idx multiplies by k; the product is kept only for a 1 exponent bit
                if (!idx[0] || exp_sr[W-1]) w <= acc;
                if (idx[0]) exp_sr <= exp_sr << 1;
                if (idx == I_LAST) state <= MUL_RD;
                idx <= idx + IW'(1);
              end
              MUL_RD: begin t <= acc; state <= ADD; end
              default: begin
                if (acc == '0) error <= 1'b1;
                else begin signature <= {r, acc}; done <= 1'b1; end
                busy <= 1'b0; state <= FINISH;
              end
            endcase
          end
        end
        ADD: begin t <= sum_red; state <= MUL_S; end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecdsa_signer.sv
// Directed bench for ecdsa_signer: an 8-bit (N=251) and a 16-bit (N=65521) instance
// with a hand-driven point-multiply engine and hand-computed signatures.
module tb_ecdsa_signer;

  localparam int L8  = 18 * 10 + 3;
  localparam int L16 = 34 * 18 + 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, pm_req, pm_ack, pm_inf, busy, done, error;
  logic [7:0]  msg_hash, priv_key, nonce_k, pm_scalar, pm_x;
  logic [15:0] signature;

  logic        b_start, b_pm_req, b_pm_ack, b_pm_inf, b_busy, b_done, b_error;
  logic [15:0] b_msg_hash, b_priv_key, b_nonce_k, b_pm_scalar, b_pm_x;
  logic [31:0] b_signature;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ecdsa_signer #(.W(8), .N(8'd251), .PM_TIMEOUT(1024)) u8 (
    .clk(clk), .rst(rst), .start(start), .msg_hash(msg_hash), .priv_key(priv_key),
    .nonce_k(nonce_k), .pm_req(pm_req), .pm_scalar(pm_scalar), .pm_ack(pm_ack),
    .pm_x(pm_x), .pm_inf(pm_inf), .signature(signature), .busy(busy), .done(done),
    .error(error));

  ecdsa_signer #(.W(16), .N(16'd65521), .PM_TIMEOUT(16)) u16 (
    .clk(clk), .rst(rst), .start(b_start), .msg_hash(b_msg_hash), .priv_key(b_priv_key),
    .nonce_k(b_nonce_k), .pm_req(b_pm_req), .pm_scalar(b_pm_scalar), .pm_ack(b_pm_ack),
    .pm_x(b_pm_x), .pm_inf(b_pm_inf), .signature(b_signature), .busy(b_busy),
    .done(b_done), .error(b_error));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_req8(input string tag);
    int n = 0;
    while (!pm_req && n < 10) begin @(negedge clk); n++; end
    check({tag, " req"}, pm_req, 1);
  endtask

  task automatic pulse_start8(input logic [7:0] z, input logic [7:0] dd, input logic [7:0] kk);
    msg_hash = z; priv_key = dd; nonce_k = kk; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // full transaction on the 8-bit instance; ok=0 expects an abort 2 cycles after the ack
  task automatic sign8(input string tag, input logic [7:0] z, input logic [7:0] dd,
                       input logic [7:0] kk, input logic [7:0] px, input logic inf,
                       input int dly, input logic ok, input logic [15:0] exp_sig);
    logic [15:0] prev;
    int n;
    prev = signature;
    pulse_start8(z, dd, kk);
    wait_req8(tag);
    check({tag, " scalar"}, pm_scalar, kk);
    repeat (dly) @(negedge clk);
    check({tag, " scalar held"}, pm_scalar, kk);
    pm_ack = 1'b1; pm_x = px; pm_inf = inf;
    @(negedge clk);
    pm_ack = 1'b0; pm_inf = 1'b0;
    check({tag, " req drop"}, pm_req, 0);
    n = 1;
    while (!(done || error) && n < L8 + 10) begin @(negedge clk); n++; end
    check({tag, " latency"}, n, ok ? L8 : 2);
    check({tag, " done"}, done, ok);
    check({tag, " error"}, error, !ok);
    check({tag, " busy"}, busy, 0);
    check({tag, " sig"}, signature, ok ? exp_sig : prev);
    @(negedge clk);
  endtask

  task automatic check_fail8(input string tag, input logic [7:0] dd, input logic [7:0] kk);
    logic [15:0] prev;
    prev = signature;
    pulse_start8(8'd9, dd, kk);
    check({tag, " busy"}, busy, 1);
    check({tag, " req1"}, pm_req, 0);
    @(negedge clk);
    check({tag, " error"}, error, 1);
    check({tag, " req2"}, pm_req, 0);
    check({tag, " done"}, done, 0);
    check({tag, " sig"}, signature, prev);
    @(negedge clk);
  endtask

  task automatic sign16(input string tag, input logic [15:0] px, input logic [31:0] exp_sig);
    int n = 0;
    b_msg_hash = '0; b_priv_key = 16'd1; b_nonce_k = 16'd1; b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    while (!b_pm_req && n < 10) begin @(negedge clk); n++; end
    check({tag, " req"}, b_pm_req, 1);
    check({tag, " scalar"}, b_pm_scalar, 16'd1);
    b_pm_ack = 1'b1; b_pm_x = px;
    @(negedge clk);
    b_pm_ack = 1'b0;
    n = 1;
    while (!(b_done || b_error) && n < L16 + 10) begin @(negedge clk); n++; end
    check({tag, " latency"}, n, L16);
    check({tag, " done"}, b_done, 1);
    check({tag, " sig"}, b_signature, exp_sig);
    @(negedge clk);
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    start = 0; msg_hash = 0; priv_key = 0; nonce_k = 0; pm_ack = 0; pm_x = 0; pm_inf = 0;
    b_start = 0; b_msg_hash = 0; b_priv_key = 0; b_nonce_k = 0; b_pm_ack = 0; b_pm_x = 0;
    b_pm_inf = 0;
    repeat (3) @(negedge clk);
    check("reset outs", {pm_req, busy, done, error, pm_scalar, signature}, 0);
    check("reset outs16", {b_pm_req, b_busy, b_done, b_error, b_pm_scalar, b_signature}, 0);
    rst = 1'b0;
    @(negedge clk);

    sign8("t1", 8'd3, 8'd1, 8'd1, 8'd5, 1'b0, 4, 1'b1, {8'd5, 8'd8});
    sign8("t2", 8'd4, 8'd3, 8'd2, 8'd10, 1'b0, 2, 1'b1, {8'd10, 8'd17});
    sign8("t2 z255", 8'd255, 8'd3, 8'd2, 8'd10, 1'b0, 0, 1'b1, {8'd10, 8'd17});
    check_fail8("d0", 8'd0, 8'd5);
    check_fail8("k251", 8'd7, 8'd251);
    check_fail8("d255", 8'd255, 8'd5);
    sign8("r0", 8'd3, 8'd1, 8'd1, 8'd251, 1'b0, 1, 1'b0, 16'd0);
    sign8("inf", 8'd3, 8'd1, 8'd1, 8'd5, 1'b1, 1, 1'b0, 16'd0);
    sign8("x253", 8'd0, 8'd1, 8'd1, 8'd253, 1'b0, 3, 1'b1, {8'd2, 8'd2});

    // engine never answers; a start mid-wait must be ignored
    pulse_start8(8'd1, 8'd2, 8'd3);
    wait_req8("tmo");
    cnt = 0;
    while (pm_req && cnt < 1100) begin
      if (cnt == 5) begin start = 1'b1; nonce_k = 8'd77; end
      else start = 1'b0;
      if (cnt == 100) check("tmo scalar", pm_scalar, 8'd3);
      cnt++;
      @(negedge clk);
    end
    start = 1'b0;
    check("tmo count", cnt, 1024);
    check("tmo error", error, 1);
    check("tmo done", done, 0);
    @(negedge clk);
    check("tmo idle", {busy, pm_req}, 0);
    sign8("after tmo", 8'd4, 8'd3, 8'd2, 8'd10, 1'b0, 1, 1'b1, {8'd10, 8'd17});

    // reset in the middle of the inversion
    pulse_start8(8'd3, 8'd1, 8'd1);
    wait_req8("rst");
    pm_ack = 1'b1; pm_x = 8'd5;
    @(negedge clk);
    pm_ack = 1'b0;
    repeat (50) @(negedge clk);
    check("rst busy pre", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst outs", {pm_req, busy, done, error, pm_scalar, signature}, 0);
    pm_ack = 1'b1; pm_x = 8'd5;
    @(negedge clk);
    pm_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("late ack", {pm_req, busy, done, error, signature}, 0);
    sign8("after rst", 8'd3, 8'd1, 8'd1, 8'd5, 1'b0, 0, 1'b1, {8'd5, 8'd8});

    sign16("w16 a", 16'd12345, {16'd12345, 16'd12345});
    sign16("w16 b", 16'd65530, {16'd9, 16'd9});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
